// File: rtl/pipe_hit_score.sv
// pipe_hit_score: collision, BCD scoring, best score, game FSM and pipe speed code
// downstream of the pipe mover stages.
module pipe_hit_score #(
    parameter logic [9:0]  GROUND_Y   = 10'd400,
    parameter int          DIE_FRAMES = 30,
    parameter logic [11:0] SPD1_BCD   = 12'h010,
    parameter logic [11:0] SPD2_BCD   = 12'h025,
    parameter logic [11:0] SPD3_BCD   = 12'h050
) (
    input  logic        system_clk,
    input  logic        reset,
    input  logic        game_clk,
    input  logic        flap,
    input  logic [9:0]  bird_l,
    input  logic [9:0]  bird_r,
    input  logic [9:0]  bird_t,
    input  logic [9:0]  bird_b,
    input  logic [9:0]  pipe_a_l,
    input  logic [9:0]  pipe_a_r,
    input  logic [9:0]  pipe_a_gap_t,
    input  logic [9:0]  pipe_a_gap_b,
    input  logic [9:0]  pipe_b_l,
    input  logic [9:0]  pipe_b_r,
    input  logic [9:0]  pipe_b_gap_t,
    input  logic [9:0]  pipe_b_gap_b,
    output logic [1:0]  state,
    output logic        game_run,
    output logic [1:0]  veciloty,
    output logic [11:0] score_bcd,
    output logic [11:0] best_bcd,
    output logic        hit
);
    localparam int DW = $clog2(DIE_FRAMES + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DYING = 2'd2, OVER = 2'd3} state_t;
    state_t cur, nxt;
    logic [2:0] game_sync, flap_sync;
    logic tick, flap_ev, ov_a, ov_b, coll, pass_a, pass_b;
    logic [9:0] prev_a_r, prev_b_r;
    logic [DW-1:0] die_cnt;
    logic [11:0] score_inc;
    // Single BCD increment, holding at 999 instead of wrapping.
    function automatic logic [11:0] bcd_inc(input logic [11:0] s);
        if (s == 12'h999) return s;
        if (s[3:0] != 4'd9) return s + 12'd1;
        if (s[7:4] != 4'd9) return {s[11:8], s[7:4] + 4'd1, 4'd0};
        return {s[11:8] + 4'd1, 8'h00};
    endfunction
    assign ov_a = bird_r >= pipe_a_l && bird_l <= pipe_a_r && (bird_t < pipe_a_gap_t || bird_b > pipe_a_gap_b);
    assign ov_b = bird_r >= pipe_b_l && bird_l <= pipe_b_r && (bird_t < pipe_b_gap_t || bird_b > pipe_b_gap_b);
    assign coll = ov_a || ov_b || bird_b >= GROUND_Y;
    // A pipe passes when its right edge moves from at/after the bird's left edge to before it.
    assign pass_a = prev_a_r >= bird_l && pipe_a_r < bird_l;
    assign pass_b = prev_b_r >= bird_l && pipe_b_r < bird_l;
    assign score_inc = (pass_a && pass_b) ? bcd_inc(bcd_inc(score_bcd)) :
                       (pass_a || pass_b) ? bcd_inc(score_bcd) : score_bcd;
    assign state = cur;
    assign game_run = cur == PLAY;
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    if (flap_ev) nxt = PLAY;
            PLAY:    if (tick && coll) nxt = DYING;
            DYING:   if (die_cnt == DW'(DIE_FRAMES)) nxt = OVER;
            default: if (flap_ev) nxt = IDLE;
        endcase
    end
    always_ff @(posedge system_clk) begin
        if (reset) begin
            cur       <= IDLE;
            game_sync <= '0;
            flap_sync <= '0;
            tick      <= 1'b0;
            flap_ev   <= 1'b0;
            prev_a_r  <= '0;
            prev_b_r  <= '0;
            die_cnt   <= '0;
            score_bcd <= '0;
            best_bcd  <= '0;
            veciloty  <= '0;
            hit       <= 1'b0;
        end else begin
            game_sync <= {game_sync[1:0], game_clk};
            flap_sync <= {flap_sync[1:0], flap};
            tick      <= game_sync[1] & ~game_sync[2];
            flap_ev   <= flap_sync[1] & ~flap_sync[2];
            cur       <= nxt;
            hit       <= cur == PLAY && tick && coll;
            veciloty  <= score_bcd >= SPD3_BCD ? 2'd3 : score_bcd >= SPD2_BCD ? 2'd2 :
                         score_bcd >= SPD1_BCD ? 2'd1 : 2'd0;
            if (tick) begin
                prev_a_r <= pipe_a_r;
                prev_b_r <= pipe_b_r;
            end
            if (cur == IDLE && flap_ev) begin
                score_bcd <= '0;
                die_cnt   <= '0;
            end else if (cur == PLAY && tick && !coll) begin
                score_bcd <= score_inc;
            end
            if (cur == DYING && tick) die_cnt <= die_cnt + 1'b1;
            if (cur == DYING && nxt == OVER && score_bcd > best_bcd) best_bcd <= score_bcd;
        end
    end
endmodule

// File: tb/tb_pipe_hit_score.sv
// tb_pipe_hit_score: directed, table-driven checks of scoring, collision and game flow.
module tb_pipe_hit_score;
    logic system_clk = 0, reset = 1, game_clk = 0, flap = 0;
    logic [9:0] bird_l = 10'd100, bird_r = 10'd120, bird_t = 10'd200, bird_b = 10'd215;
    logic [9:0] pipe_a_l = 10'd600, pipe_a_r = 10'd639, pipe_a_gap_t = 10'd0, pipe_a_gap_b = 10'd399;
    logic [9:0] pipe_b_l = 10'd600, pipe_b_r = 10'd639, pipe_b_gap_t = 10'd0, pipe_b_gap_b = 10'd399;
    logic [1:0] state, veciloty;
    logic game_run, hit;
    logic [11:0] score_bcd, best_bcd;
    int passed = 0, total = 0, hit_cnt = 0, h0;
    typedef struct {
        logic [9:0]  a_r;
        logic [11:0] exp_score;
    } vec_t;
    vec_t vt[5];

    pipe_hit_score dut (
        .system_clk(system_clk), .reset(reset), .game_clk(game_clk), .flap(flap),
        .bird_l(bird_l), .bird_r(bird_r), .bird_t(bird_t), .bird_b(bird_b),
        .pipe_a_l(pipe_a_l), .pipe_a_r(pipe_a_r), .pipe_a_gap_t(pipe_a_gap_t), .pipe_a_gap_b(pipe_a_gap_b),
        .pipe_b_l(pipe_b_l), .pipe_b_r(pipe_b_r), .pipe_b_gap_t(pipe_b_gap_t), .pipe_b_gap_b(pipe_b_gap_b),
        .state(state), .game_run(game_run), .veciloty(veciloty),
        .score_bcd(score_bcd), .best_bcd(best_bcd), .hit(hit)
    );

    always #5 system_clk = ~system_clk;
    always @(negedge system_clk) if (hit) hit_cnt++;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick_t();
        @(negedge system_clk) game_clk = 1;
        repeat (4) @(negedge system_clk);
        game_clk = 0;
        repeat (4) @(negedge system_clk);
    endtask

    task automatic flap_t();
        @(negedge system_clk) flap = 1;
        repeat (4) @(negedge system_clk);
        flap = 0;
        repeat (4) @(negedge system_clk);
    endtask

    // One (n=1) or two (n=2) pipes cross the bird, then jump back to the right edge.
    task automatic pass_n(input int n);
        pipe_a_r = 10'd99;
        if (n == 2) pipe_b_r = 10'd99;
        tick_t();
        pipe_a_r = 10'd639;
        pipe_b_r = 10'd639;
        tick_t();
    endtask

    initial begin
        vt[0] = '{10'd101, 12'h000};
        vt[1] = '{10'd100, 12'h000};
        vt[2] = '{10'd99,  12'h001};
        vt[3] = '{10'd639, 12'h001};
        vt[4] = '{10'd639, 12'h001};
        repeat (3) @(negedge system_clk);
        reset = 0;
        chk("rst_state", state, 0);
        chk("rst_run", game_run, 0);
        chk("rst_vel", veciloty, 0);
        chk("rst_score", score_bcd, 0);
        chk("rst_best", best_bcd, 0);
        chk("rst_hit", hit, 0);
        flap_t();
        chk("play_state", state, 1);
        chk("play_run", game_run, 1);
        foreach (vt[i]) begin
            pipe_a_r = vt[i].a_r;
            tick_t();
            chk($sformatf("vec%0d_score", i), score_bcd, vt[i].exp_score);
        end
        repeat (6) pass_n(1);
        chk("score7", score_bcd, 12'h007);
        @(negedge system_clk) reset = 1;
        @(negedge system_clk);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_score", score_bcd, 0);
        chk("mid_rst_best", best_bcd, 0);
        chk("mid_rst_vel", veciloty, 0);
        chk("mid_rst_run", game_run, 0);
        reset = 0;
        tick_t();
        flap_t();
        chk("replay_score", score_bcd, 0);
        repeat (9) pass_n(1);
        chk("score9", score_bcd, 12'h009);
        chk("vel0_at9", veciloty, 0);
        pass_n(2);
        chk("double_pass", score_bcd, 12'h011);
        chk("vel1", veciloty, 1);
        pipe_a_l = 10'd110; pipe_a_r = 10'd150; pipe_a_gap_t = 10'd220; pipe_a_gap_b = 10'd300;
        h0 = hit_cnt;
        tick_t();
        chk("coll_hit_once", hit_cnt - h0, 1);
        chk("coll_dying", state, 2);
        chk("coll_score", score_bcd, 12'h011);
        pipe_a_l = 10'd600; pipe_a_r = 10'd639; pipe_a_gap_t = 10'd0; pipe_a_gap_b = 10'd399;
        flap_t();
        chk("flap_in_dying", state, 2);
        repeat (29) tick_t();
        chk("dying_29", state, 2);
        tick_t();
        chk("over_30", state, 3);
        chk("best11", best_bcd, 12'h011);
        flap_t();
        chk("over_to_idle", state, 0);
        chk("idle_keeps_score", score_bcd, 12'h011);
        flap_t();
        chk("idle_to_play", state, 1);
        chk("play_clears", score_bcd, 0);
        repeat (7) pass_n(2);
        pass_n(1);
        chk("score15", score_bcd, 12'h015);
        bird_b = 10'd399;
        tick_t();
        chk("ground_minus1", state, 1);
        bird_b = 10'd400;
        tick_t();
        chk("ground_hit", state, 2);
        bird_b = 10'd215;
        repeat (30) tick_t();
        chk("over2", state, 3);
        chk("best15", best_bcd, 12'h015);
        flap_t();
        flap_t();
        chk("play3", state, 1);
        repeat (6) pass_n(2);
        chk("score12", score_bcd, 12'h012);
        bird_b = 10'd400;
        tick_t();
        bird_b = 10'd215;
        repeat (30) tick_t();
        chk("over3", state, 3);
        chk("best_kept", best_bcd, 12'h015);
        flap_t();
        chk("idle3", state, 0);
        chk("idle3_score", score_bcd, 12'h012);
        flap_t();
        chk("play4", state, 1);
        chk("play4_score", score_bcd, 0);
        repeat (12) pass_n(2);
        chk("vel1_at24", veciloty, 1);
        pass_n(1);
        chk("score25", score_bcd, 12'h025);
        chk("vel2", veciloty, 2);
        repeat (12) pass_n(2);
        pass_n(1);
        chk("score50", score_bcd, 12'h050);
        chk("vel3", veciloty, 3);
        repeat (474) pass_n(2);
        chk("score998", score_bcd, 12'h998);
        pass_n(2);
        chk("sat_999", score_bcd, 12'h999);
        pass_n(1);
        chk("sat_hold", score_bcd, 12'h999);
        chk("vel3_sat", veciloty, 3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
